// File: rtl/fetch_decode_pipe.sv
// Fetch and decode front end of a pipelined Y86-64 style processor.
// Fetch reads a variable-length instruction from a byte-addressed memory,
// predicts the next PC, and hands the fields to the F/D register. Decode
// selects the source registers and reads them, with write-back bypass.
module fetch_decode_pipe #(
    parameter int WIDTH      = 64,
    parameter int IMEM_BYTES = 1024,
    parameter int NUM_REGS   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_stall,
    input  logic             d_stall,
    input  logic             d_bubble,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             imem_wr_en,
    input  logic [WIDTH-1:0] imem_wr_addr,
    input  logic [7:0]       imem_wr_data,
    input  logic             wb_en,
    input  logic [3:0]       wb_dst,
    input  logic [WIDTH-1:0] wb_val,
    output logic [WIDTH-1:0] f_pc,
    output logic [3:0]       d_icode,
    output logic [3:0]       d_ifun,
    output logic [3:0]       d_rA,
    output logic [3:0]       d_rB,
    output logic [WIDTH-1:0] d_valC,
    output logic [WIDTH-1:0] d_valP,
    output logic [WIDTH-1:0] d_valA,
    output logic [WIDTH-1:0] d_valB,
    output logic [2:0]       d_stat,
    output logic             d_reg_error
);

    localparam int               AW        = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [WIDTH-1:0] IMEM_SIZE = WIDTH'(IMEM_BYTES);
    localparam logic [3:0]       REG_CNT   = 4'(NUM_REGS);
    localparam logic [3:0]       RNONE     = 4'hF;
    localparam logic [3:0]       RSP       = 4'h4;
    localparam logic [2:0]       STAT_AOK  = 3'd1;
    localparam logic [2:0]       STAT_HLT  = 3'd2;
    localparam logic [2:0]       STAT_ADR  = 3'd3;
    localparam logic [2:0]       STAT_INS  = 3'd4;

    typedef struct packed {
        logic [3:0]       icode;
        logic [3:0]       ifun;
        logic [3:0]       ra;
        logic [3:0]       rb;
        logic [WIDTH-1:0] valc;
        logic [WIDTH-1:0] valp;
        logic [2:0]       stat;
    } fd_t;

    // The nop that a bubble (and reset) places in the F/D register.
    function automatic fd_t bubble_fd();
        fd_t b;
        b.icode = 4'h1;
        b.ifun  = 4'h0;
        b.ra    = RNONE;
        b.rb    = RNONE;
        b.valc  = '0;
        b.valp  = '0;
        b.stat  = STAT_AOK;
        return b;
    endfunction

    logic [7:0]       imem_r [IMEM_BYTES];
    logic [WIDTH-1:0] regs_r [NUM_REGS];
    logic [WIDTH-1:0] f_pc_r;
    fd_t              fd_r;

    logic [AW-1:0]    fidx_s  [10];
    logic [7:0]       fbyte_s [10];
    logic [3:0]       f_len_s;
    logic             f_has_regs_s;
    logic             f_fun_ok_s;
    logic             f_adr_s;
    logic [63:0]      f_valc64_s;
    logic [WIDTH-1:0] f_pred_s;
    fd_t              fetch_s;
    logic [3:0]       srca_s;
    logic [3:0]       srcb_s;

    // Register-file read: index F and unimplemented indices return 0,
    // a same-cycle write to the index is forwarded.
    function automatic logic [WIDTH-1:0] rf_read(input logic [3:0] idx);
        logic [WIDTH-1:0] v;
        if ((idx == RNONE) || (idx >= REG_CNT)) begin
            v = '0;
        end else if (wb_en && (wb_dst == idx)) begin
            v = wb_val;
        end else begin
            v = regs_r[idx];
        end
        return v;
    endfunction

    // Program loader byte write; instruction memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (imem_wr_en && (imem_wr_addr < IMEM_SIZE)) begin
            imem_r[imem_wr_addr[AW-1:0]] <= imem_wr_data;
        end
    end

    // Gather the ten candidate bytes at f_pc; bytes beyond memory read as 0.
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            fidx_s[i] = f_pc_r[AW-1:0] + AW'(i);
            if ((f_pc_r < IMEM_SIZE) && ((IMEM_SIZE - f_pc_r) > WIDTH'(i))) begin
                fbyte_s[i] = imem_r[fidx_s[i]];
            end else begin
                fbyte_s[i] = 8'h00;
            end
        end
    end

    // Split the fetched bytes into fields, length, status and predicted PC.
    always_comb begin
        f_len_s      = 4'd1;
        f_has_regs_s = 1'b0;
        f_valc64_s   = 64'd0;
        case (fbyte_s[0][7:4])
            4'h0, 4'h1, 4'h9: begin
                f_len_s = 4'd1;
            end
            4'h2, 4'h6, 4'hA, 4'hB: begin
                f_len_s      = 4'd2;
                f_has_regs_s = 1'b1;
            end
            4'h7, 4'h8: begin
                f_len_s    = 4'd9;
                f_valc64_s = {fbyte_s[8], fbyte_s[7], fbyte_s[6], fbyte_s[5],
                              fbyte_s[4], fbyte_s[3], fbyte_s[2], fbyte_s[1]};
            end
            4'h3, 4'h4, 4'h5: begin
                f_len_s      = 4'd10;
                f_has_regs_s = 1'b1;
                f_valc64_s   = {fbyte_s[9], fbyte_s[8], fbyte_s[7], fbyte_s[6],
                                fbyte_s[5], fbyte_s[4], fbyte_s[3], fbyte_s[2]};
            end
            default: begin
                f_len_s = 4'd1;
            end
        endcase

        case (fbyte_s[0][7:4])
            4'h2:    f_fun_ok_s = (fbyte_s[0][3:0] <= 4'd6);
            4'h6:    f_fun_ok_s = (fbyte_s[0][3:0] <= 4'd3);
            4'h7:    f_fun_ok_s = (fbyte_s[0][3:0] <= 4'd6);
            default: f_fun_ok_s = (fbyte_s[0][3:0] == 4'd0);
        endcase

        f_adr_s = !((f_pc_r < IMEM_SIZE) && ((IMEM_SIZE - f_pc_r) >= WIDTH'(f_len_s)));

        fetch_s.icode = fbyte_s[0][7:4];
        fetch_s.ifun  = fbyte_s[0][3:0];
        fetch_s.ra    = f_has_regs_s ? fbyte_s[1][7:4] : RNONE;
        fetch_s.rb    = f_has_regs_s ? fbyte_s[1][3:0] : RNONE;
        fetch_s.valc  = WIDTH'(f_valc64_s);
        fetch_s.valp  = f_pc_r + WIDTH'(f_len_s);

        if (f_adr_s) begin
            fetch_s.stat = STAT_ADR;
        end else if ((fetch_s.icode > 4'hB) || !f_fun_ok_s) begin
            fetch_s.stat = STAT_INS;
        end else if (fetch_s.icode == 4'h0) begin
            fetch_s.stat = STAT_HLT;
        end else begin
            fetch_s.stat = STAT_AOK;
        end

        if ((fetch_s.icode == 4'h7) || (fetch_s.icode == 4'h8)) begin
            f_pred_s = fetch_s.valc;
        end else begin
            f_pred_s = fetch_s.valp;
        end
    end

    // Fetch PC: redirect wins, then stall, then freeze on a faulting fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pc_r <= '0;
        end else if (redirect_valid) begin
            f_pc_r <= redirect_pc;
        end else if (f_stall) begin
            f_pc_r <= f_pc_r;
        end else if (fetch_s.stat != STAT_AOK) begin
            f_pc_r <= f_pc_r;
        end else begin
            f_pc_r <= f_pred_s;
        end
    end

    // F/D pipeline register: bubble beats stall beats load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fd_r <= bubble_fd();
        end else if (d_bubble) begin
            fd_r <= bubble_fd();
        end else if (d_stall) begin
            fd_r <= fd_r;
        end else begin
            fd_r <= fetch_s;
        end
    end

    // Register file write port; writes to unimplemented indices are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wb_en && (wb_dst < REG_CNT)) begin
            regs_r[wb_dst] <= wb_val;
        end
    end

    // Decode: pick source registers from icode and read them.
    always_comb begin
        case (fd_r.icode)
            4'h2, 4'h4, 4'h6, 4'hA: srca_s = fd_r.ra;
            4'h9, 4'hB:             srca_s = RSP;
            default:                srca_s = RNONE;
        endcase
        case (fd_r.icode)
            4'h4, 4'h5, 4'h6:       srcb_s = fd_r.rb;
            4'h8, 4'h9, 4'hA, 4'hB: srcb_s = RSP;
            default:                srcb_s = RNONE;
        endcase

        if ((fd_r.icode == 4'h7) || (fd_r.icode == 4'h8)) begin
            d_valA = fd_r.valp;
        end else begin
            d_valA = rf_read(srca_s);
        end
        d_valB      = rf_read(srcb_s);
        d_reg_error = ((srca_s != RNONE) && (srca_s >= REG_CNT)) ||
                      ((srcb_s != RNONE) && (srcb_s >= REG_CNT));
    end

    assign f_pc    = f_pc_r;
    assign d_icode = fd_r.icode;
    assign d_ifun  = fd_r.ifun;
    assign d_rA    = fd_r.ra;
    assign d_rB    = fd_r.rb;
    assign d_valC  = fd_r.valc;
    assign d_valP  = fd_r.valp;
    assign d_stat  = fd_r.stat;

endmodule

// File: doc/fetch_decode_pipe.md
FETCH_DECODE_PIPE -- requirements
Module: fetch_decode_pipe

Interface
REQ-001 Parameter WIDTH, default 64, sets the data/PC width (valC, valP, register contents).
REQ-002 Parameter IMEM_BYTES, default 1024, sets the byte-addressed instruction memory depth.
REQ-003 Parameter NUM_REGS, default 15, sets the number of implemented registers (1..15); index 4'hF means "none".
REQ-004 One clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 f_stall  in  1  hold fetch PC.
REQ-006 d_stall  in  1  hold the F/D register.
REQ-007 d_bubble  in  1  load a nop into the F/D register.
REQ-008 redirect_valid  in  1; redirect_pc  in  WIDTH  PC correction from later stages.
REQ-009 imem_wr_en  in  1; imem_wr_addr  in  WIDTH; imem_wr_data  in  8  program-loader byte write.
REQ-010 wb_en  in  1; wb_dst  in  4; wb_val  in  WIDTH  register-file write port.
REQ-011 f_pc  out  WIDTH  current fetch PC.
REQ-012 d_icode, d_ifun, d_rA, d_rB  out  4 each; d_valC, d_valP, d_valA, d_valB  out  WIDTH; d_stat  out  3; d_reg_error  out  1  decode-stage outputs.

Function
REQ-013 Fetch SHALL read 1 to 10 bytes at f_pc: byte0 = {icode, ifun}; byte1 = {rA, rB} when present; valC little-endian, 8 bytes.
REQ-014 Length: icode 0,1,9 -> 1; icode 2,6,A,B -> 2; icode 7,8 -> 9 (valC at byte1); icode 3,4,5 -> 10; valP = f_pc + length.
REQ-015 Absent fields SHALL read as rA = rB = F and valC = 0.
REQ-016 Fetch stat: ADR (3) if any instruction byte address >= IMEM_BYTES (out-of-range bytes read 0); else INS (4) if icode > B, or ifun invalid (2: 0-6, 6: 0-3, 7: 0-6, others: 0); else HLT (2) if icode 0; else AOK (1). ADR has priority over INS.
REQ-017 Predicted PC = valC for icode 7 or 8, else valP.
REQ-018 f_pc update per edge, in priority order: redirect_valid -> redirect_pc; f_stall -> hold; fetched stat != AOK -> hold (fetch frozen); else -> predicted PC.
REQ-019 F/D register update per edge, in priority order: d_bubble -> bubble (icode 1, ifun 0, rA = rB = F, valC = valP = 0, stat AOK); d_stall -> hold; else -> load fetched fields.
REQ-020 srcA = rA for icode 2,4,6,A; 4 (RSP) for icode 9,B; else F. srcB = rB for icode 4,5,6; 4 for icode 8,9,A,B; else F.
REQ-021 d_valA = d_valP for icode 7 or 8; else the register-file read of srcA. d_valB = the register-file read of srcB.
REQ-022 Reading index F SHALL return 0.
REQ-023 Read bypass: if wb_en and wb_dst equals the source index (not F), the read SHALL return wb_val in the same cycle.
REQ-024 Register write happens at the edge when wb_en is set and wb_dst < NUM_REGS; writes with wb_dst >= NUM_REGS (including F) are ignored.
REQ-025 d_reg_error = 1 when srcA or srcB is not F and is >= NUM_REGS; that read returns 0.
REQ-026 Loader writes one byte per edge when imem_wr_en is set and the address is < IMEM_BYTES; other writes are dropped.
REQ-027 A same-cycle loader write and fetch read of the same byte SHALL return the old byte.
REQ-028 Decode outputs are combinational from the F/D register plus the register file; fetch-to-decode latency is exactly 1 cycle.

Reset
REQ-029 While rst_n = 0: f_pc = 0, the F/D register holds the bubble of REQ-019, and all registers = 0. Resulting outputs: d_valA = d_valB = 0, d_reg_error = 0.
REQ-030 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge.
REQ-031 Instruction memory contents are not affected by reset.

Verification
REQ-032 Load 30 F2 05 00 00 00 00 00 00 00 at 0, release reset, one edge -> d_icode 3, d_rB 2, d_valC 5, d_valP 10, d_stat 1, f_pc 10.
REQ-033 Load 70 20 00 00 00 00 00 00 00 at 0, one edge -> f_pc 0x20, d_valA 9.
REQ-034 Hold f_stall = d_stall = 1 for two edges -> f_pc and all d_* outputs unchanged; assert d_bubble together with d_stall -> d_icode 1, d_rA F, d_stat 1.
REQ-035 Place byte C0 at f_pc, one edge -> d_stat 4 and f_pc frozen; redirect_valid = 1 with redirect_pc 0 -> f_pc 0 on the next edge.
REQ-036 Place an instruction at IMEM_BYTES-2 -> d_stat 3; wb_en = 1, wb_dst 2, wb_val 7 with d_rA 2 (icode 6) -> d_valA 7 in the same cycle and register 2 = 7 after the edge.
REQ-037 Drop rst_n between clock edges mid-program -> f_pc 0 and d_icode 1 before the next edge.
